// File: rtl/multi_list_pkg.sv
// Shared opcodes, error codes and FSM encoding for the multi-list node engine.
package multi_list_pkg;

    localparam logic [2:0] OpPushFront = 3'b000;
    localparam logic [2:0] OpPushBack  = 3'b001;
    localparam logic [2:0] OpPopFront  = 3'b010;
    localparam logic [2:0] OpDelete    = 3'b011;
    localparam logic [2:0] OpTraverse  = 3'b100;
    localparam logic [2:0] OpClear     = 3'b101;

    localparam logic [1:0] ErrOk    = 2'd0;
    localparam logic [1:0] ErrFull  = 2'd1;
    localparam logic [1:0] ErrEmpty = 2'd2;
    localparam logic [1:0] ErrKey   = 2'd3;

    typedef enum logic [2:0] {
        StInit,
        StIdle,
        StSearch,
        StFree,
        StStream,
        StPopOut,
        StClear
    } state_e;

endpackage

// File: rtl/list_node_mem.sv
// Node pool storage: payload and next-pointer arrays with one write and one async read port each.
// After reset it walks every node once, chaining node i to i+1 and zeroing its payload.
module list_node_mem
    import multi_list_pkg::*;
#(
    parameter int unsigned NUM_NODES = 32,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned PTR_W     = $clog2(NUM_NODES + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic              init_last,
    input  logic              data_we,
    input  logic [PTR_W-1:0]  data_waddr,
    input  logic [DATA_W-1:0] data_wdata,
    input  logic              next_we,
    input  logic [PTR_W-1:0]  next_waddr,
    input  logic [PTR_W-1:0]  next_wdata,
    input  logic [PTR_W-1:0]  rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic [PTR_W-1:0]  rd_next
);

    // One spare slot at the NULL index keeps reads of NULL in range.
    logic [DATA_W-1:0] data_mem [NUM_NODES+1];
    logic [PTR_W-1:0]  next_mem [NUM_NODES+1];
    logic [PTR_W-1:0]  init_idx_q;
    logic              init_busy_q;

    assign init_last = init_busy_q && (init_idx_q == PTR_W'(NUM_NODES - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            init_idx_q  <= '0;
            init_busy_q <= 1'b1;
        end else if (init_busy_q) begin
            init_idx_q <= init_idx_q + 1'b1;
            if (init_last) begin
                init_busy_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (init_busy_q) begin
            data_mem[init_idx_q] <= '0;
            next_mem[init_idx_q] <= init_idx_q + 1'b1;
        end else begin
            if (data_we) begin
                data_mem[data_waddr] <= data_wdata;
            end
            if (next_we) begin
                next_mem[next_waddr] <= next_wdata;
            end
        end
    end

    assign rd_data = data_mem[rd_addr];
    assign rd_next = next_mem[rd_addr];

endmodule

// File: rtl/multi_list_engine.sv
// NUM_LISTS singly-linked lists sharing one node pool and free list, driven by a valid/ready
// command port and emitting pop/traverse payloads on a back-pressured output stream.
module multi_list_engine
    import multi_list_pkg::*;
#(
    parameter int unsigned NUM_NODES = 32,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned NUM_LISTS = 4,
    parameter int unsigned PTR_W     = $clog2(NUM_NODES + 1),
    parameter int unsigned LIST_W    = (NUM_LISTS > 1) ? $clog2(NUM_LISTS) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [LIST_W-1:0] cmd_list,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              done,
    output logic [1:0]        err,
    output logic [PTR_W-1:0]  free_count
);

    localparam logic [PTR_W-1:0] NullPtr = PTR_W'(NUM_NODES);
    localparam logic [PTR_W-1:0] OnePtr  = PTR_W'(1);

    state_e            state_q, state_d;
    logic [PTR_W-1:0]  head_q [NUM_LISTS];
    logic [PTR_W-1:0]  head_d [NUM_LISTS];
    logic [PTR_W-1:0]  tail_q [NUM_LISTS];
    logic [PTR_W-1:0]  tail_d [NUM_LISTS];
    logic [PTR_W-1:0]  count_q [NUM_LISTS];
    logic [PTR_W-1:0]  count_d [NUM_LISTS];
    logic [PTR_W-1:0]  free_head_q, free_head_d, free_count_q, free_count_d;
    logic [PTR_W-1:0]  cur_q, cur_d, prev_q, prev_d;
    logic [LIST_W-1:0] sel_q, sel_d;
    logic [DATA_W-1:0] key_q, key_d, out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d, out_last_q, out_last_d, done_q, done_d;
    logic [1:0]        err_q, err_d;

    logic              init_last, data_we, next_we;
    logic [PTR_W-1:0]  data_waddr, next_waddr, next_wdata, rd_addr, rd_next;
    logic [DATA_W-1:0] data_wdata, rd_data;

    logic              accept, list_ok, is_push, cur_is_tail, key_hit;
    logic [PTR_W-1:0]  cmd_head, cmd_tail, cmd_cnt, sel_cnt;
    logic [1:0]        cmd_err;

    list_node_mem #(
        .NUM_NODES (NUM_NODES),
        .DATA_W    (DATA_W),
        .PTR_W     (PTR_W)
    ) u_mem (
        .clk        (clk),
        .reset_n    (reset_n),
        .init_last  (init_last),
        .data_we    (data_we),
        .data_waddr (data_waddr),
        .data_wdata (data_wdata),
        .next_we    (next_we),
        .next_waddr (next_waddr),
        .next_wdata (next_wdata),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_next    (rd_next)
    );

    assign accept      = cmd_valid && cmd_ready;
    assign list_ok     = 32'(cmd_list) < NUM_LISTS;
    assign is_push     = (cmd_op == OpPushFront) || (cmd_op == OpPushBack);
    assign cmd_head    = head_q[cmd_list];
    assign cmd_tail    = tail_q[cmd_list];
    assign cmd_cnt     = count_q[cmd_list];
    assign sel_cnt     = count_q[sel_q];
    assign cur_is_tail = (cur_q == tail_q[sel_q]);
    assign key_hit     = (rd_data == key_q);

    always_comb begin
        if (!list_ok || (cmd_op > OpClear)) begin
            cmd_err = ErrKey;
        end else if (is_push) begin
            cmd_err = (free_count_q == '0) ? ErrFull : ErrOk;
        end else begin
            cmd_err = (cmd_cnt == '0) ? ErrEmpty : ErrOk;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StInit;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StInit:   if (init_last) state_d = StIdle;
            StIdle: begin
                if (accept && (cmd_err == ErrOk)) begin
                    case (cmd_op)
                        OpPopFront: state_d = StPopOut;
                        OpDelete:   state_d = StSearch;
                        OpTraverse: state_d = StStream;
                        OpClear:    state_d = StClear;
                        default:    state_d = StIdle;
                    endcase
                end
            end
            StSearch: begin
                if (key_hit) begin
                    state_d = StFree;
                end else if (cur_is_tail) begin
                    state_d = StIdle;
                end
            end
            StFree:   state_d = StIdle;
            StStream: if (out_valid_q && out_ready && out_last_q) state_d = StIdle;
            StPopOut: if (out_ready) state_d = StIdle;
            StClear:  if (cur_is_tail) state_d = StIdle;
            default:  state_d = StInit;
        endcase
    end

    always_comb begin
        cmd_ready = (state_q == StIdle);
        rd_addr   = cur_q;
        if (state_q == StIdle) begin
            rd_addr = is_push ? free_head_q : cmd_head;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_last   = out_last_q;
    assign done       = done_q;
    assign err        = err_q;
    assign free_count = free_count_q;

    // The tail's next pointer is never trusted: walks stop on tail, so pushes need one next write.
    always_comb begin
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        free_head_d  = free_head_q;
        free_count_d = free_count_q;
        cur_d        = cur_q;
        prev_d       = prev_q;
        sel_d        = sel_q;
        key_d        = key_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_last_d   = out_last_q;
        done_d       = 1'b0;
        err_d        = ErrOk;
        data_we      = 1'b0;
        data_waddr   = free_head_q;
        data_wdata   = cmd_data;
        next_we      = 1'b0;
        next_waddr   = cur_q;
        next_wdata   = free_head_q;

        case (state_q)
            StInit: begin
                if (init_last) begin
                    free_head_d  = '0;
                    free_count_d = PTR_W'(NUM_NODES);
                end
            end
            StIdle: begin
                if (accept) begin
                    sel_d = cmd_list;
                    if (cmd_err != ErrOk) begin
                        done_d = 1'b1;
                        err_d  = cmd_err;
                    end else if (is_push) begin
                        data_we      = 1'b1;
                        free_head_d  = rd_next;
                        free_count_d = free_count_q - 1'b1;
                        count_d[cmd_list] = cmd_cnt + 1'b1;
                        done_d       = 1'b1;
                        if (cmd_op == OpPushFront) begin
                            next_we    = 1'b1;
                            next_waddr = free_head_q;
                            next_wdata = cmd_head;
                            head_d[cmd_list] = free_head_q;
                            if (cmd_cnt == '0) tail_d[cmd_list] = free_head_q;
                        end else begin
                            if (cmd_cnt == '0) begin
                                head_d[cmd_list] = free_head_q;
                            end else begin
                                next_we    = 1'b1;
                                next_waddr = cmd_tail;
                                next_wdata = free_head_q;
                            end
                            tail_d[cmd_list] = free_head_q;
                        end
                    end else begin
                        cur_d  = cmd_head;
                        prev_d = NullPtr;
                        key_d  = cmd_data;
                        if (cmd_op == OpPopFront) begin
                            out_valid_d = 1'b1;
                            out_data_d  = rd_data;
                            out_last_d  = 1'b1;
                        end
                    end
                end
            end
            StSearch: begin
                if (key_hit) begin
                    count_d[sel_q] = sel_cnt - 1'b1;
                    if (prev_q == NullPtr) begin
                        head_d[sel_q] = (sel_cnt == OnePtr) ? NullPtr : rd_next;
                    end else begin
                        next_we    = 1'b1;
                        next_waddr = prev_q;
                        next_wdata = rd_next;
                    end
                    if (cur_is_tail) tail_d[sel_q] = prev_q;
                end else if (cur_is_tail) begin
                    done_d = 1'b1;
                    err_d  = ErrKey;
                end else begin
                    prev_d = cur_q;
                    cur_d  = rd_next;
                end
            end
            StFree: begin
                next_we      = 1'b1;
                free_head_d  = cur_q;
                free_count_d = free_count_q + 1'b1;
                done_d       = 1'b1;
            end
            StStream: begin
                if (!out_valid_q || out_ready) begin
                    if (out_valid_q && out_last_q) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        done_d      = 1'b1;
                    end else begin
                        out_valid_d = 1'b1;
                        out_data_d  = rd_data;
                        out_last_d  = cur_is_tail;
                        cur_d       = rd_next;
                    end
                end
            end
            StPopOut: begin
                if (out_ready) begin
                    out_valid_d    = 1'b0;
                    out_last_d     = 1'b0;
                    next_we        = 1'b1;
                    free_head_d    = cur_q;
                    free_count_d   = free_count_q + 1'b1;
                    count_d[sel_q] = sel_cnt - 1'b1;
                    head_d[sel_q]  = (sel_cnt == OnePtr) ? NullPtr : rd_next;
                    if (sel_cnt == OnePtr) tail_d[sel_q] = NullPtr;
                    done_d         = 1'b1;
                end
            end
            StClear: begin
                next_we      = 1'b1;
                free_head_d  = cur_q;
                free_count_d = free_count_q + 1'b1;
                if (cur_is_tail) begin
                    head_d[sel_q]  = NullPtr;
                    tail_d[sel_q]  = NullPtr;
                    count_d[sel_q] = '0;
                    done_d         = 1'b1;
                end else begin
                    cur_d = rd_next;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NUM_LISTS; i++) begin
                head_q[i]  <= NullPtr;
                tail_q[i]  <= NullPtr;
                count_q[i] <= '0;
            end
            free_head_q  <= '0;
            free_count_q <= '0;
            cur_q        <= NullPtr;
            prev_q       <= NullPtr;
            sel_q        <= '0;
            key_q        <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= ErrOk;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            free_head_q  <= free_head_d;
            free_count_q <= free_count_d;
            cur_q        <= cur_d;
            prev_q       <= prev_d;
            sel_q        <= sel_d;
            key_q        <= key_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

endmodule
